hazard_scoreboard_unit: RTL and testbench
=========================================

# hazard_scoreboard_unit

Parametrised hazard unit for the superscalar core, replacing the single-lane load-use/flush unit. It tracks pending load destinations in a per-register countdown scoreboard, which supports multi-cycle load latency. It raises a bundle-level decode stall for any lane that reads a pending register. It also resolves branch mispredicts across ISSUE_W execute lanes, reporting the oldest mispredicting lane for PC correction.

## Interface
- ISSUE_W, 2: issue lanes (1..4); lane 0 is oldest.
- NUM_REGS, 32: architectural registers; register 0 is hard-wired zero.
- LOAD_LAT, 1: cycles a load destination stays unavailable after issue (1..7).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- valid_d  in  ISSUE_W  lane holds a valid instruction in decode.
- rs_d, rt_d  in  ISSUE_W*5  source register indices; lane i occupies bits [5i+4:5i].
- write_reg_d  in  ISSUE_W*5  destination index per lane.
- mem_read_d  in  ISSUE_W  lane is a load.
- branch_e, taken_e, prediction_e  in  ISSUE_W  execute-stage branch, actual outcome, and predicted outcome per lane.
- pc_src  in  1  unconditional redirect (jump resolved in decode).
- stall  out  1  hold the PC and decode bundle.
- flush  out  1  squash the decode bundle and younger stages.
- cpc_signal  out  1  correct the PC because of a mispredict.
- cpc_lane  out  clog2(ISSUE_W) (minimum 1)  index of the oldest mispredicting lane.
- busy  out  NUM_REGS  debug view; bit r = (counter[r] != 0).
- stall_cnt, flush_cnt, mispredict_cnt  out  32 each  performance counters (see Configuration).

## Operation
- Mispredict of lane i: branch_e[i] & (taken_e[i] ^ prediction_e[i]).
  - cpc_signal = OR over all lanes of the mispredict terms.
  - cpc_lane = lowest mispredicting lane index; 0 when there is none.
- flush = cpc_signal | pc_src.
- Hazard on lane i: valid_d[i], and rs_d[i] or rt_d[i] is nonzero with counter[src] != 0.
- stall = (OR of all lane hazards) & ~flush. The stall is bundle-wide; no partial issue.
- Intra-bundle dependencies are resolved by the upstream pairing logic and are not checked here.
- fire = ~stall & ~flush. Each lane with fire & valid_d & mem_read_d and write_reg_d != 0 loads counter[write_reg_d] with LOAD_LAT.
- Every other nonzero counter decrements by 1 each cycle; zero counters hold.
- Set has priority over decrement. Re-setting a pending register restarts it at LOAD_LAT.
- Two lanes in one bundle loading the same destination produce a single set to LOAD_LAT.
- A flush does not clear the scoreboard. Entries left by squashed younger loads only add conservative stalls.

## Timing
- Reset: all counters 0, busy=0, perf counters 0.
- stall, flush, cpc_signal, and cpc_lane are combinational from the inputs and counters, so they are 0 while reset is held with idle inputs.
- A load fires in cycle t:
  - counter = LOAD_LAT at t+1 and 1 at t+LOAD_LAT.
  - A consumer in decode stalls from t+1 through t+LOAD_LAT and proceeds at t+LOAD_LAT+1.
- With LOAD_LAT=1, behaviour matches the classic single-bubble load-use stall.
- Counter width is clog2(LOAD_LAT+1).
- Reset asserted mid-countdown clears all counters immediately (asynchronous).
- When flush and a hazard occur together, flush=1 and stall=0, and no scoreboard set occurs that cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments each cycle stall=1.
  - flush_cnt increments each cycle flush=1.
  - mispredict_cnt increments each cycle cpc_signal=1.
  - All three are 32-bit and wrap on overflow.
- Undefined: the three ports remain and are tied to 0, with no counter flops.

## Structure
- Shared package hazard_pkg holds:
  - REG_IDX_W=5.
  - The lane-slice helper function for packed index buses.
  - The function computing the counter width from LOAD_LAT.
- Sub-module hazard_sb_counter: one register's countdown counter with set/decrement priority, instantiated NUM_REGS times. Its instance for register 0 is omitted and tied to zero.

## Test plan
- Test 1: ISSUE_W=2, LOAD_LAT=1. Lane 0 load to r5 fires at t; lane 1 reads r5 at t+1. Required: stall=1 at t+1 only, busy[5]=0 at t+2.
- Test 2: LOAD_LAT=3. Load to r7 at t; consumer held in decode. Required: stall=1 at t+1..t+3, released at t+4. Re-issuing a load to r7 at t+2 extends the stall to t+5.
- Test 3: Load to r0. Required: busy stays 0 and a consumer of r0 never stalls.
- Test 4: Lanes 0 and 1 both mispredict, lane 1 only mispredicts, and pc_src alone. Required respectively: cpc_lane=0 with flush=1, cpc_lane=1, and flush=1 with cpc_signal=0.
- Test 5: Hazard and mispredict in the same cycle. Required: stall=0, flush=1, no busy bit set. Then assert reset with counter[9]=2. Required: busy[9]=0 before the next clock edge.
- Test 6: With HAZARD_PERF_CNT_EN, 4 stall cycles and 2 flushes. Required: stall_cnt=4, flush_cnt=2. Without the macro, all counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the hazard scoreboard unit.
package hazard_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned MAX_LANES = 4;

  // Width that holds LOAD_LAT without overflow.
  function automatic int unsigned cntWidth(input int unsigned loadLat);
    return $clog2(loadLat + 1);
  endfunction

  // Extract one lane's register index from a (zero-padded) packed bus.
  function automatic logic [REG_IDX_W-1:0] laneIdx(input logic [MAX_LANES*REG_IDX_W-1:0] bus,
                                                   input int unsigned lane);
    return bus[lane*REG_IDX_W +: REG_IDX_W];
  endfunction

endpackage

// File: rtl/hazard_sb_counter.sv
// Countdown for one architectural register; set has priority over decrement.
module hazard_sb_counter
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = cntWidth(LOAD_LAT)
) (
  input  logic clk,
  input  logic reset,
  input  logic set,
  output logic busy
);

  logic [CNT_W-1:0] countQ, countD;

  always_comb begin
    countD = countQ;
    if (set) begin
      countD = CNT_W'(LOAD_LAT);
    end else if (countQ != '0) begin
      countD = countQ - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      countQ <= '0;
    end else begin
      countQ <= countD;
    end
  end

  assign busy = (countQ != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Multi-lane load-use scoreboard and oldest-lane mispredict resolver.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned ISSUE_W  = 2,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned LOAD_LAT = 1,
  localparam int unsigned LANE_W  = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ISSUE_W-1:0]             valid_d,
  input  logic [ISSUE_W*REG_IDX_W-1:0]   rs_d,
  input  logic [ISSUE_W*REG_IDX_W-1:0]   rt_d,
  input  logic [ISSUE_W*REG_IDX_W-1:0]   write_reg_d,
  input  logic [ISSUE_W-1:0]             mem_read_d,
  input  logic [ISSUE_W-1:0]             branch_e,
  input  logic [ISSUE_W-1:0]             taken_e,
  input  logic [ISSUE_W-1:0]             prediction_e,
  input  logic                           pc_src,
  output logic                           stall,
  output logic                           flush,
  output logic                           cpc_signal,
  output logic [LANE_W-1:0]              cpc_lane,
  output logic [NUM_REGS-1:0]            busy,
  output logic [31:0]                    stall_cnt,
  output logic [31:0]                    flush_cnt,
  output logic [31:0]                    mispredict_cnt
);

  logic [ISSUE_W-1:0]              mispredict;
  logic [MAX_LANES*REG_IDX_W-1:0]  rsPad, rtPad, wrPad;
  logic [REG_IDX_W-1:0]            rsIdx, rtIdx, wrIdx;
  logic                            anyHazard, fire;
  logic [NUM_REGS-1:0]             setVec, busyVec;

  // Lowest mispredicting lane wins: scan from youngest down so the oldest overwrites.
  always_comb begin
    mispredict = branch_e & (taken_e ^ prediction_e);
    cpc_signal = |mispredict;
    cpc_lane   = '0;
    for (int i = ISSUE_W - 1; i >= 0; i--) begin
      if (mispredict[i]) cpc_lane = LANE_W'(i);
    end
  end

  always_comb begin
    rsPad = '0;
    rtPad = '0;
    wrPad = '0;
    rsPad[ISSUE_W*REG_IDX_W-1:0] = rs_d;
    rtPad[ISSUE_W*REG_IDX_W-1:0] = rt_d;
    wrPad[ISSUE_W*REG_IDX_W-1:0] = write_reg_d;
  end

  always_comb begin
    anyHazard = 1'b0;
    rsIdx     = '0;
    rtIdx     = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      rsIdx = laneIdx(rsPad, i);
      rtIdx = laneIdx(rtPad, i);
      if (valid_d[i] && (((rsIdx != '0) && busyVec[rsIdx]) ||
                         ((rtIdx != '0) && busyVec[rtIdx]))) begin
        anyHazard = 1'b1;
      end
    end
  end

  assign flush = cpc_signal | pc_src;
  assign stall = anyHazard & ~flush;
  assign fire  = ~stall & ~flush;

  // Duplicate destinations within a bundle simply OR into one set.
  always_comb begin
    setVec = '0;
    wrIdx  = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      wrIdx = laneIdx(wrPad, i);
      if (fire && valid_d[i] && mem_read_d[i] && (wrIdx != '0)) setVec[wrIdx] = 1'b1;
    end
  end

  assign busyVec[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : gen_sb
    hazard_sb_counter #(
      .LOAD_LAT (LOAD_LAT)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .set   (setVec[r]),
      .busy  (busyVec[r])
    );
  end

  assign busy = busyVec;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCntQ, flushCntQ, mispredictCntQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCntQ      <= '0;
      flushCntQ      <= '0;
      mispredictCntQ <= '0;
    end else begin
      if (stall)      stallCntQ      <= stallCntQ + 32'd1;
      if (flush)      flushCntQ      <= flushCntQ + 32'd1;
      if (cpc_signal) mispredictCntQ <= mispredictCntQ + 32'd1;
    end
  end

  assign stall_cnt      = stallCntQ;
  assign flush_cnt      = flushCntQ;
  assign mispredict_cnt = mispredictCntQ;
`else
  assign stall_cnt      = '0;
  assign flush_cnt      = '0;
  assign mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench: two instances (LOAD_LAT=1 and LOAD_LAT=3) share one stimulus bus.
module tb_hazard_scoreboard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  validD, memReadD, branchE, takenE, predE;
  logic [9:0]  rsD, rtD, wrD;
  logic        pcSrc;

  logic        stall1, flush1, cpcSig1;
  logic [0:0]  cpcLane1;
  logic [31:0] busy1, stallCnt1, flushCnt1, mispCnt1;
  logic        stall3, flush3, cpcSig3;
  logic [0:0]  cpcLane3;
  logic [31:0] busy3, stallCnt3, flushCnt3, mispCnt3;

  int nVec = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.ISSUE_W(2), .NUM_REGS(32), .LOAD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .valid_d(validD), .rs_d(rsD), .rt_d(rtD), .write_reg_d(wrD),
    .mem_read_d(memReadD), .branch_e(branchE), .taken_e(takenE), .prediction_e(predE),
    .pc_src(pcSrc), .stall(stall1), .flush(flush1), .cpc_signal(cpcSig1), .cpc_lane(cpcLane1),
    .busy(busy1), .stall_cnt(stallCnt1), .flush_cnt(flushCnt1), .mispredict_cnt(mispCnt1)
  );

  hazard_scoreboard_unit #(.ISSUE_W(2), .NUM_REGS(32), .LOAD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .valid_d(validD), .rs_d(rsD), .rt_d(rtD), .write_reg_d(wrD),
    .mem_read_d(memReadD), .branch_e(branchE), .taken_e(takenE), .prediction_e(predE),
    .pc_src(pcSrc), .stall(stall3), .flush(flush3), .cpc_signal(cpcSig3), .cpc_lane(cpcLane3),
    .busy(busy3), .stall_cnt(stallCnt3), .flush_cnt(flushCnt3), .mispredict_cnt(mispCnt3)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle;
    validD = '0; memReadD = '0; branchE = '0; takenE = '0; predE = '0;
    rsD = '0; rtD = '0; wrD = '0; pcSrc = 1'b0;
  endtask

  task automatic doReset;
    reset = 1'b1;
    setIdle();
    tick();
    reset = 1'b0;
  endtask

  // Lane-0 load to rd; lane 1 idle.
  task automatic loadLane0(input logic [4:0] rd);
    setIdle();
    validD = 2'b01; memReadD = 2'b01; wrD = {5'd0, rd};
  endtask

  // Lane-0 consumer reading rs.
  task automatic useLane0(input logic [4:0] rs);
    setIdle();
    validD = 2'b01; rsD = {5'd0, rs};
  endtask

  initial begin
    reset = 1'b1;
    setIdle();
    #2;
    checkVal("rst_stall", {31'd0, stall1}, 32'd0);
    checkVal("rst_flush", {31'd0, flush1}, 32'd0);
    checkVal("rst_cpc", {31'd0, cpcSig1}, 32'd0);
    checkVal("rst_busy", busy3, 32'd0);
    checkVal("rst_perf", stallCnt3 | flushCnt3 | mispCnt3, 32'd0);
    tick();
    reset = 1'b0;

    // Test 1: LOAD_LAT=1 single-bubble load-use.
    loadLane0(5'd5);
    #1 checkVal("t1_fire_nostall", {31'd0, stall1}, 32'd0);
    tick();
    setIdle();
    validD = 2'b10; rsD = {5'd5, 5'd0};
    #1 checkVal("t1_stall", {31'd0, stall1}, 32'd1);
    checkVal("t1_busy5", {31'd0, busy1[5]}, 32'd1);
    tick();
    #1 checkVal("t1_release", {31'd0, stall1}, 32'd0);
    checkVal("t1_busy5_clr", {31'd0, busy1[5]}, 32'd0);

    // Test 2: LOAD_LAT=3 with a re-issued load.
    doReset();
    loadLane0(5'd7);
    tick();
    useLane0(5'd7);
    for (int k = 1; k <= 3; k++) begin
      #1 checkVal($sformatf("t2_stall_t%0d", k), {31'd0, stall3}, 32'd1);
      tick();
    end
    #1 checkVal("t2_release_t4", {31'd0, stall3}, 32'd0);
    doReset();
    loadLane0(5'd7);
    tick();
    setIdle();
    #1 checkVal("t2_busy7", {31'd0, busy3[7]}, 32'd1);
    tick();
    loadLane0(5'd7);
    #1 checkVal("t2_reload_fires", {31'd0, stall3}, 32'd0);
    tick();
    useLane0(5'd7);
    for (int k = 3; k <= 5; k++) begin
      #1 checkVal($sformatf("t2_ext_stall_t%0d", k), {31'd0, stall3}, 32'd1);
      tick();
    end
    #1 checkVal("t2_ext_release_t6", {31'd0, stall3}, 32'd0);

    // Test 3: load to r0 never marks busy.
    doReset();
    loadLane0(5'd0);
    tick();
    useLane0(5'd0);
    #1 checkVal("t3_busy1", busy1, 32'd0);
    checkVal("t3_busy3", busy3, 32'd0);
    checkVal("t3_stall", {31'd0, stall3}, 32'd0);

    // Test 4: mispredict lane selection and pc_src.
    setIdle();
    branchE = 2'b11; takenE = 2'b11; predE = 2'b00;
    #1 checkVal("t4_both_lane", {31'd0, cpcLane1}, 32'd0);
    checkVal("t4_both_flush", {31'd0, flush1}, 32'd1);
    checkVal("t4_both_cpc", {31'd0, cpcSig1}, 32'd1);
    takenE = 2'b10;
    #1 checkVal("t4_l1_lane", {31'd0, cpcLane1}, 32'd1);
    checkVal("t4_l1_cpc", {31'd0, cpcSig1}, 32'd1);
    setIdle();
    pcSrc = 1'b1;
    #1 checkVal("t4_pcsrc_flush", {31'd0, flush1}, 32'd1);
    checkVal("t4_pcsrc_cpc", {31'd0, cpcSig1}, 32'd0);
    setIdle();
    #1 checkVal("t4_idle_flush", {31'd0, flush1}, 32'd0);

    // Test 5: hazard with mispredict, then async reset mid-countdown.
    doReset();
    loadLane0(5'd9);
    tick();
    setIdle();
    validD = 2'b11; rsD = {5'd0, 5'd9}; memReadD = 2'b10; wrD = {5'd10, 5'd0};
    branchE = 2'b01; takenE = 2'b01; predE = 2'b00;
    #1 checkVal("t5_stall", {31'd0, stall3}, 32'd0);
    checkVal("t5_flush", {31'd0, flush3}, 32'd1);
    tick();
    setIdle();
    #1 checkVal("t5_no_set10", {31'd0, busy3[10]}, 32'd0);
    checkVal("t5_busy9", {31'd0, busy3[9]}, 32'd1);
    reset = 1'b1;
    #1 checkVal("t5_async_busy9", {31'd0, busy3[9]}, 32'd0);
    checkVal("t5_async_all", busy3, 32'd0);
    tick();
    reset = 1'b0;

    // Test 6: 4 stall cycles, 2 flush cycles (one of them a mispredict).
    doReset();
    loadLane0(5'd7);
    tick();
    useLane0(5'd7);
    tick(); tick(); tick();
    setIdle();
    validD = 2'b01; rsD = {5'd0, 5'd7}; memReadD = 2'b01; wrD = {5'd0, 5'd8};
    #1 checkVal("t6_chain_fire", {31'd0, stall3}, 32'd0);
    tick();
    useLane0(5'd8);
    #1 checkVal("t6_stall4", {31'd0, stall3}, 32'd1);
    tick();
    pcSrc = 1'b1;
    tick();
    setIdle();
    branchE = 2'b01; takenE = 2'b00; predE = 2'b01;
    tick();
    setIdle();
    #1;
`ifdef HAZARD_PERF_CNT_EN
    checkVal("t6_stall_cnt", stallCnt3, 32'd4);
    checkVal("t6_flush_cnt", flushCnt3, 32'd2);
    checkVal("t6_misp_cnt", mispCnt3, 32'd1);
`else
    checkVal("t6_stall_cnt", stallCnt3, 32'd0);
    checkVal("t6_flush_cnt", flushCnt3, 32'd0);
    checkVal("t6_misp_cnt", mispCnt3, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
